hash_msg_feeder: RTL and testbench

HASH_MSG_FEEDER -- requirements
Module: hash_msg_feeder

---
 rtl/hash_msg_feeder.sv | 83 ++++++++
 tb/tb_hash_msg_feeder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/hash_msg_feeder.sv
// hash_msg_feeder: feeds a byte-length message from 32-bit words into a byte-wide hash core; HASH_DIGEST_CHECK_EN adds expected/match.
module hash_msg_feeder #(
  parameter int LEN_W = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             msg_start,
  input  logic [LEN_W-1:0] msg_len,
  input  logic [31:0]      word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             hash_start,
  output logic [7:0]       hash_byte,
  output logic             hash_byte_valid,
  input  logic             core_ready,
  output logic             hash_last,
  input  logic [31:0]      digest_in,
  input  logic             digest_valid,
  output logic [31:0]      digest,
  output logic             done,
`ifdef HASH_DIGEST_CHECK_EN
  input  logic [31:0]      expected,
  output logic             match,
`endif
  output logic             busy
);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, LOAD = 3'd2, SEND = 3'd3, WAIT_DIG = 3'd4, DONE = 3'd5;
  localparam logic [31:0] ZERO_DIGEST = 32'h3FA1EF23;
  logic [2:0] state;
  logic [LEN_W-1:0] rem;
  logic [2:0] cnt;
  logic [31:0] shift;
  logic cap_zero, cap_dig;
  assign cap_zero = state == START && rem == '0;
  assign cap_dig = state == WAIT_DIG && digest_valid;
  assign busy = state != IDLE;
  assign hash_start = state == START;
  assign word_ready = state == LOAD;
  assign hash_byte_valid = state == SEND;
  assign hash_byte = shift[31:24];
  assign hash_last = hash_byte_valid && rem == LEN_W'(1);
  assign done = state == DONE;
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
      rem <= '0;
      cnt <= '0;
      shift <= '0;
      digest <= '0;
    end else begin
      if (cap_zero) digest <= ZERO_DIGEST;
      if (cap_dig) digest <= digest_in;
      case (state)
        IDLE: if (msg_start) begin
          rem <= msg_len;
          state <= START;
        end
        START: state <= rem == '0 ? DONE : LOAD;
        LOAD: if (word_valid) begin
          shift <= word_in;
          cnt <= rem > LEN_W'(3) ? 3'd4 : 3'(rem);
          state <= SEND;
        end
        SEND: if (core_ready) begin
          // low bytes of a short final word simply never reach the top
          shift <= {shift[23:0], 8'h00};
          rem <= rem - LEN_W'(1);
          cnt <= cnt - 3'd1;
          state <= rem == LEN_W'(1) ? WAIT_DIG : cnt == 3'd1 ? LOAD : SEND;
        end
        WAIT_DIG: if (digest_valid) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef HASH_DIGEST_CHECK_EN
  always_ff @(posedge clock) begin
    if (rst) match <= 1'b0;
    else if (cap_zero) match <= expected == ZERO_DIGEST;
    else if (cap_dig) match <= digest_in == expected;
  end
`endif
endmodule

// File: tb/tb_hash_msg_feeder.sv
// tb_hash_msg_feeder: directed self-checking bench for hash_msg_feeder.
module tb_hash_msg_feeder;
  logic clock, rst, msg_start, word_valid, word_ready, hash_start, hash_byte_valid;
  logic core_ready, hash_last, digest_valid, done, busy;
  logic [15:0] msg_len;
  logic [31:0] word_in, digest_in, digest;
  logic [7:0] hash_byte;
`ifdef HASH_DIGEST_CHECK_EN
  logic [31:0] expected;
  logic match;
`endif
  int checks = 0, errors = 0;
  logic [31:0] words[4];
  logic [7:0] got[16];
  int bcyc[16];
  int nb, nwr, nhs, stab_err, last_idx, nlast;

  hash_msg_feeder #(.LEN_W(16)) dut (
    .clock(clock), .rst(rst), .msg_start(msg_start), .msg_len(msg_len),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .hash_start(hash_start), .hash_byte(hash_byte), .hash_byte_valid(hash_byte_valid),
    .core_ready(core_ready), .hash_last(hash_last), .digest_in(digest_in),
    .digest_valid(digest_valid), .digest(digest), .done(done),
`ifdef HASH_DIGEST_CHECK_EN
    .expected(expected), .match(match),
`endif
    .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts a message and streams it to completion, recording accepted bytes.
  task automatic run(input int len, input logic [15:0] pat, input bit inj);
    int wi = 0, cyc = 0, sp = 0;
    logic [7:0] held = '0;
    bit stalled = 0;
    nb = 0; nwr = 0; nhs = 0; stab_err = 0; last_idx = -1; nlast = 0;
    msg_start = 1'b1; msg_len = 16'(len); core_ready = 1'b1;
    tick();
    msg_start = 1'b0;
    while (nb < len && cyc < 60) begin
      msg_start = inj && hash_byte_valid;
      msg_len = 16'd1;
      core_ready = hash_byte_valid ? pat[sp % 16] : 1'b1;
      if (hash_byte_valid) sp++;
      word_valid = word_ready;
      word_in = word_ready ? words[wi] : 32'h0;
      if (word_ready) begin
        nwr++;
        wi++;
      end
      if (hash_start) nhs++;
      if (stalled && hash_byte !== held) stab_err++;
      if (hash_byte_valid && core_ready) begin
        got[nb] = hash_byte;
        bcyc[nb] = cyc;
        if (hash_last) begin
          last_idx = nb;
          nlast++;
        end
        nb++;
      end
      stalled = hash_byte_valid && !core_ready;
      held = hash_byte;
      tick();
      cyc++;
    end
    msg_start = 1'b0; word_valid = 1'b0; core_ready = 1'b1;
    chk("run_len", 32'(nb), 32'(len));
    chk("wait_dig_valid", {31'b0, hash_byte_valid}, 32'd0);
    chk("wait_dig_busy", {31'b0, busy}, 32'd1);
  endtask

  task automatic finish_dig(input logic [31:0] d);
    digest_valid = 1'b1; digest_in = d;
`ifdef HASH_DIGEST_CHECK_EN
    expected = d;
`endif
    tick();
    digest_valid = 1'b0;
    chk("done_pulse", {31'b0, done}, 32'd1);
    chk("digest_cap", digest, d);
`ifdef HASH_DIGEST_CHECK_EN
    chk("match", {31'b0, match}, 32'd1);
`endif
    tick();
    chk("done_end", {31'b0, done}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; msg_start = 1'b0; msg_len = '0; word_in = '0; word_valid = 1'b0;
    core_ready = 1'b1; digest_in = '0; digest_valid = 1'b0;
`ifdef HASH_DIGEST_CHECK_EN
    expected = '0;
`endif
    tick();
    tick();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_digest", digest, 32'd0);
    chk("rst_outs", {27'b0, hash_start, word_ready, hash_byte_valid, hash_last, done}, 32'd0);
    rst = 1'b0;
    tick();
    chk("no_start_after_rst", {31'b0, hash_start}, 32'd0);

    // 5-byte message over two words, core always ready
    words[0] = 32'hAABBCCDD; words[1] = 32'hEE000000;
    run(5, 16'hFFFF, 0);
    chk("t1_b0", {24'b0, got[0]}, 32'hAA);
    chk("t1_b1", {24'b0, got[1]}, 32'hBB);
    chk("t1_b2", {24'b0, got[2]}, 32'hCC);
    chk("t1_b3", {24'b0, got[3]}, 32'hDD);
    chk("t1_b4", {24'b0, got[4]}, 32'hEE);
    chk("t1_last_idx", 32'(last_idx), 32'd4);
    chk("t1_nlast", 32'(nlast), 32'd1);
    chk("t1_word_ready", 32'(nwr), 32'd2);
    chk("t1_hash_start", 32'(nhs), 32'd1);
    chk("t1_backtoback", 32'(bcyc[3] - bcyc[0]), 32'd3);
    chk("t1_reload_gap", 32'(bcyc[4] - bcyc[3]), 32'd2);
    finish_dig(32'h12345678);

    // stray digest_valid in IDLE is ignored
    digest_valid = 1'b1; digest_in = 32'hDEADBEEF;
    tick();
    digest_valid = 1'b0;
    chk("stray_digest", digest, 32'h12345678);
    chk("stray_done", {31'b0, done}, 32'd0);
    chk("stray_busy", {31'b0, busy}, 32'd0);

    // core_ready toggling 1,0,1,0 while sending
    words[0] = 32'h01020304;
    run(4, 16'h5555, 0);
    chk("t2_b0", {24'b0, got[0]}, 32'h01);
    chk("t2_b1", {24'b0, got[1]}, 32'h02);
    chk("t2_b2", {24'b0, got[2]}, 32'h03);
    chk("t2_b3", {24'b0, got[3]}, 32'h04);
    chk("t2_stable", 32'(stab_err), 32'd0);
    chk("t2_last_idx", 32'(last_idx), 32'd3);
    finish_dig(32'hCAFEF00D);

    // zero-length message
    msg_start = 1'b1; msg_len = 16'd0;
    tick();
    msg_start = 1'b0;
    chk("z_hash_start", {31'b0, hash_start}, 32'd1);
    chk("z_no_byte", {31'b0, hash_byte_valid}, 32'd0);
    chk("z_no_done_yet", {31'b0, done}, 32'd0);
    tick();
    chk("z_done", {31'b0, done}, 32'd1);
    chk("z_digest", digest, 32'h3FA1EF23);
    chk("z_no_byte2", {31'b0, hash_byte_valid}, 32'd0);
    tick();
    chk("z_idle", {31'b0, busy}, 32'd0);

    // reset after two of four bytes
    msg_start = 1'b1; msg_len = 16'd4;
    tick();
    msg_start = 1'b0;
    tick();
    chk("r_load", {31'b0, word_ready}, 32'd1);
    word_valid = 1'b1; word_in = 32'h11223344;
    tick();
    word_valid = 1'b0;
    chk("r_b0", {24'b0, hash_byte}, 32'h11);
    tick();
    chk("r_b1", {24'b0, hash_byte}, 32'h22);
    tick();
    chk("r_b2_pending", {24'b0, hash_byte}, 32'h33);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_busy", {31'b0, busy}, 32'd0);
    chk("r_digest", digest, 32'd0);
    chk("r_outs", {19'b0, hash_byte, hash_start, word_ready, hash_byte_valid, hash_last, done}, 32'd0);
    words[0] = 32'h55667788;
    run(4, 16'hFFFF, 0);
    chk("r_n0", {24'b0, got[0]}, 32'h55);
    chk("r_n1", {24'b0, got[1]}, 32'h66);
    chk("r_n2", {24'b0, got[2]}, 32'h77);
    chk("r_n3", {24'b0, got[3]}, 32'h88);
    chk("r_hash_start", 32'(nhs), 32'd1);
    finish_dig(32'h0BADC0DE);

    // msg_start during SEND is ignored; partial final word discards low bytes
    words[0] = 32'hA1A2A3A4; words[1] = 32'hB1B2C3C4;
    run(6, 16'hFFFF, 1);
    chk("i_b3", {24'b0, got[3]}, 32'hA4);
    chk("i_b4", {24'b0, got[4]}, 32'hB1);
    chk("i_b5", {24'b0, got[5]}, 32'hB2);
    chk("i_last_idx", 32'(last_idx), 32'd5);
    chk("i_word_ready", 32'(nwr), 32'd2);
    finish_dig(32'h600DF00D);
    tick();
    chk("i_no_restart", {31'b0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
